// File: rtl/chroma_stream_arbiter_if.sv
// Packed YUV422 stream channel shared by the decoder outputs and the chroma converter.
interface nasti_stream_channel #(
    parameter int DATA_W = 64
) ();
    logic [DATA_W-1:0]   t_data;
    logic [DATA_W/8-1:0] t_keep;
    logic                t_last;
    logic                t_valid;
    logic                t_ready;

    modport master (
        output t_data,
        output t_keep,
        output t_last,
        output t_valid,
        input  t_ready
    );

    modport slave (
        input  t_data,
        input  t_keep,
        input  t_last,
        input  t_valid,
        output t_ready
    );
endinterface

// File: rtl/chroma_stream_arbiter.sv
// Packet-granular round-robin arbiter feeding one chroma converter from two YUV422 sources,
// with a single registered output stage so dst.t_ready reaches upstream through one gate level.
module chroma_stream_arbiter #(
    parameter int PKT_CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    nasti_stream_channel.slave   src0,
    nasti_stream_channel.slave   src1,
    nasti_stream_channel.master  dst,
    input  logic [1:0]           en,
    output logic [1:0]           grant,
    output logic                 busy,
    output logic [PKT_CNT_W-1:0] pkt_cnt0,
    output logic [PKT_CNT_W-1:0] pkt_cnt1
);

    localparam int DATA_W = 64;
    localparam int KEEP_W = DATA_W / 8;

    // One-hot owner encoding doubles as the registered grant output.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        OWN0 = 2'b01,
        OWN1 = 2'b10
    } state_t;

    state_t              state_reg;
    state_t              state_next;
    logic                rr_reg;
    logic                rr_next;
    logic [1:0]          state_bits;

    logic                dst_valid_reg;
    logic                dst_valid_next;
    logic [DATA_W-1:0]   dst_data_reg;
    logic [DATA_W-1:0]   dst_data_next;
    logic [KEEP_W-1:0]   dst_keep_reg;
    logic [KEEP_W-1:0]   dst_keep_next;
    logic                dst_last_reg;
    logic                dst_last_next;
    logic                dst_owner_reg;
    logic                dst_owner_next;

    logic [1:0]          src_valid;
    logic [1:0]          src_last;
    logic [DATA_W-1:0]   src_data [2];
    logic [KEEP_W-1:0]   src_keep [2];
    logic [1:0]          src_ready;
    logic [1:0]          src_hs;
    logic [1:0]          cand;

    logic                dst_free;
    logic                dst_hs;
    logic                beat_accept;
    logic                beat_src;

    assign src_valid   = {src1.t_valid, src0.t_valid};
    assign src_last    = {src1.t_last, src0.t_last};
    assign src_data[0] = src0.t_data;
    assign src_data[1] = src1.t_data;
    assign src_keep[0] = src0.t_keep;
    assign src_keep[1] = src1.t_keep;

    assign state_bits  = state_reg;
    assign dst_free    = !dst_valid_reg || dst.t_ready;
    assign dst_hs      = dst_valid_reg && dst.t_ready;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_src
            logic [PKT_CNT_W-1:0] cnt_reg;

            assign src_ready[gi] = state_bits[gi] && dst_free;
            assign src_hs[gi]    = src_valid[gi] && src_ready[gi];
            assign cand[gi]      = src_valid[gi] && en[gi];

            // Count packets as they leave on dst, attributed by the owner tag of that beat.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    cnt_reg <= '0;
                end else if (dst_hs && dst_last_reg && (dst_owner_reg == 1'(gi))) begin
                    cnt_reg <= cnt_reg + 1'b1;
                end
            end
        end
    endgenerate

    assign src0.t_ready = src_ready[0];
    assign src1.t_ready = src_ready[1];
    assign beat_accept  = |src_hs;
    assign beat_src     = src_hs[1];

    always_comb begin
        state_next = state_reg;
        rr_next    = rr_reg;
        case (state_reg)
            IDLE: begin
                if (cand == 2'b11) begin
                    state_next = rr_reg ? OWN1 : OWN0;
                end else if (cand[0]) begin
                    state_next = OWN0;
                end else if (cand[1]) begin
                    state_next = OWN1;
                end
            end
            OWN0: begin
                if (src_hs[0] && src_last[0]) begin
                    state_next = IDLE;
                    rr_next    = 1'b1;
                end
            end
            OWN1: begin
                if (src_hs[1] && src_last[1]) begin
                    state_next = IDLE;
                    rr_next    = 1'b0;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Output register: reload on every accepted beat, otherwise hold while stalled.
    always_comb begin
        dst_valid_next = dst_valid_reg;
        dst_data_next  = dst_data_reg;
        dst_keep_next  = dst_keep_reg;
        dst_last_next  = dst_last_reg;
        dst_owner_next = dst_owner_reg;
        if (beat_accept) begin
            dst_valid_next = 1'b1;
            dst_data_next  = src_data[beat_src];
            dst_keep_next  = src_keep[beat_src];
            dst_last_next  = src_last[beat_src];
            dst_owner_next = beat_src;
        end else if (dst.t_ready) begin
            dst_valid_next = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg     <= IDLE;
            rr_reg        <= 1'b0;
            dst_valid_reg <= 1'b0;
            dst_data_reg  <= '0;
            dst_keep_reg  <= '0;
            dst_last_reg  <= 1'b0;
            dst_owner_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            rr_reg        <= rr_next;
            dst_valid_reg <= dst_valid_next;
            dst_data_reg  <= dst_data_next;
            dst_keep_reg  <= dst_keep_next;
            dst_last_reg  <= dst_last_next;
            dst_owner_reg <= dst_owner_next;
        end
    end

    assign dst.t_valid = dst_valid_reg;
    assign dst.t_data  = dst_data_reg;
    assign dst.t_keep  = dst_keep_reg;
    assign dst.t_last  = dst_last_reg;

    assign grant    = state_bits;
    assign busy     = (state_reg != IDLE) || dst_valid_reg;
    assign pkt_cnt0 = g_src[0].cnt_reg;
    assign pkt_cnt1 = g_src[1].cnt_reg;

endmodule

// File: tb/tb_chroma_stream_arbiter.sv
// Scoreboard bench for chroma_stream_arbiter: random packets from both sources, a packet-order
// model of the round-robin policy, and a negedge monitor that checks every dst beat.
`timescale 1ns/1ps
module tb_chroma_stream_arbiter;

    localparam int CW     = 4;
    localparam int BUDGET = 400;

    typedef struct packed {
        logic [63:0] data;
        logic [7:0]  keep;
        logic        last;
    } beat_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [1:0]       en;
    logic [1:0]       s_valid;
    logic [63:0]      s_data [2];
    logic [7:0]       s_keep [2];
    logic [1:0]       s_last;
    logic             d_ready;
    logic [1:0]       grant;
    logic             busy;
    logic [CW-1:0]    pkt_cnt0;
    logic [CW-1:0]    pkt_cnt1;

    nasti_stream_channel src0_if ();
    nasti_stream_channel src1_if ();
    nasti_stream_channel dst_if ();

    assign src0_if.t_valid = s_valid[0];
    assign src0_if.t_data  = s_data[0];
    assign src0_if.t_keep  = s_keep[0];
    assign src0_if.t_last  = s_last[0];
    assign src1_if.t_valid = s_valid[1];
    assign src1_if.t_data  = s_data[1];
    assign src1_if.t_keep  = s_keep[1];
    assign src1_if.t_last  = s_last[1];
    assign dst_if.t_ready  = d_ready;

    chroma_stream_arbiter #(.PKT_CNT_W(CW)) dut (
        .clk      (clk),
        .rst      (rst),
        .src0     (src0_if),
        .src1     (src1_if),
        .dst      (dst_if),
        .en       (en),
        .grant    (grant),
        .busy     (busy),
        .pkt_cnt0 (pkt_cnt0),
        .pkt_cnt1 (pkt_cnt1)
    );

    always #5 clk = ~clk;

    int            vecs = 0;
    int            fails = 0;
    beat_t         src_q [2][$];
    beat_t         exp_q [2][$];
    int            ord_q [$];
    int            cur_src = -1;
    logic [CW-1:0] cnt_model [2];
    logic          rr_model = 1'b0;
    bit            mon_en = 1'b0;
    bit            rnd_ready = 1'b0;

    task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
        vecs++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_msg(input string name, input string what);
        vecs++;
        fails++;
        $display("FAIL %s: %s at %0t", name, what, $time);
    endtask

    // Monitor: forwarding latency, stall stability, packet order, beat contents and counters.
    beat_t prev_src_beat;
    beat_t prev_dst_beat;
    bit    prev_src_hs = 1'b0;
    bit    prev_stall  = 1'b0;

    always @(negedge clk) begin
        beat_t cur_dst;
        beat_t exp_b;
        bit    hs0;
        bit    hs1;
        cur_dst = {dst_if.t_data, dst_if.t_keep, dst_if.t_last};
        hs0 = s_valid[0] && src0_if.t_ready;
        hs1 = s_valid[1] && src1_if.t_ready;
        if (!mon_en) begin
            prev_src_hs = 1'b0;
            prev_stall  = 1'b0;
        end else begin
            chk("pkt_cnt0", pkt_cnt0, cnt_model[0]);
            chk("pkt_cnt1", pkt_cnt1, cnt_model[1]);
            chk("grant_onehot", grant == 2'b11, 1'b0);
            if (prev_src_hs) begin
                chk("fwd_valid", dst_if.t_valid, 1'b1);
                chk("fwd_beat", cur_dst, prev_src_beat);
            end
            if (prev_stall) begin
                chk("stall_valid", dst_if.t_valid, 1'b1);
                chk("stall_hold", cur_dst, prev_dst_beat);
            end
            if (dst_if.t_valid && !d_ready) begin
                chk("stall_src_ready", {src1_if.t_ready, src0_if.t_ready}, 2'b00);
            end
            if (dst_if.t_valid && d_ready) begin
                if (cur_src < 0) begin
                    if (ord_q.size() == 0) fail_msg("order", "packet on dst with none expected");
                    else cur_src = ord_q.pop_front();
                end
                if (cur_src >= 0) begin
                    if (exp_q[cur_src].size() == 0) begin
                        fail_msg("dst_beat", "beat on dst with empty source queue");
                    end else begin
                        exp_b = exp_q[cur_src].pop_front();
                        chk("dst_beat", cur_dst, exp_b);
                    end
                end
                if (dst_if.t_last) begin
                    if (cur_src >= 0) cnt_model[cur_src] = cnt_model[cur_src] + 1'b1;
                    cur_src = -1;
                end
            end
            prev_src_hs   = hs0 || hs1;
            prev_src_beat = hs1 ? {s_data[1], s_keep[1], s_last[1]} : {s_data[0], s_keep[0], s_last[0]};
            prev_stall    = dst_if.t_valid && !d_ready;
            prev_dst_beat = cur_dst;
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rnd_ready) d_ready = ($urandom_range(99) < 70);
        end
    end

    task automatic gen_pkt(input int i, input int len);
        for (int k = 0; k < len; k++) begin
            beat_t b;
            b.data = {$urandom, $urandom};
            b.keep = ($urandom_range(3) == 0) ? 8'($urandom_range(1, 255)) : 8'hFF;
            b.last = (k == len - 1);
            src_q[i].push_back(b);
        end
    endtask

    task automatic drive_src(input int i, input int gap_pct);
        bit first;
        first = 1'b1;
        while (src_q[i].size() > 0) begin
            beat_t b;
            int    n;
            bit    hs;
            b = src_q[i].pop_front();
            if (first && gap_pct > 0) begin
                while ($urandom_range(99) < gap_pct) begin
                    @(posedge clk);
                    #1;
                end
            end
            s_valid[i] = 1'b1;
            s_data[i]  = b.data;
            s_keep[i]  = b.keep;
            s_last[i]  = b.last;
            exp_q[i].push_back(b);
            n  = 0;
            hs = 1'b0;
            while (!hs && n < BUDGET) begin
                @(negedge clk);
                hs = (i == 0) ? src0_if.t_ready : src1_if.t_ready;
                n++;
            end
            if (!hs) fail_msg("src_accept", $sformatf("src%0d beat not accepted in %0d cycles", i, BUDGET));
            @(posedge clk);
            #1;
            s_valid[i] = 1'b0;
            first = b.last;
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q[0].size() != 0 || exp_q[1].size() != 0 || ord_q.size() != 0 || dst_if.t_valid)
               && n < BUDGET) begin
            @(negedge clk);
            n++;
        end
        if (n == BUDGET) fail_msg("drain", "dst did not empty in time");
        chk("idle_grant", grant, 2'b00);
        chk("idle_busy", busy, 1'b0);
        @(posedge clk);
        #1;
    endtask

    // Both sources always valid: packets alternate, starting with the source the rr pointer names.
    task automatic run_both(input int n, input int minlen, input int maxlen);
        logic first;
        first = rr_model;
        for (int k = 0; k < n; k++) begin
            gen_pkt(0, $urandom_range(minlen, maxlen));
            gen_pkt(1, $urandom_range(minlen, maxlen));
            ord_q.push_back(int'(first));
            ord_q.push_back(int'(!first));
        end
        fork
            drive_src(0, 0);
            drive_src(1, 0);
            begin
                @(negedge clk);
                chk("arb_bubble_grant", grant, 2'b00);
                @(negedge clk);
                chk("arb_first_grant", grant, first ? 2'b10 : 2'b01);
            end
        join
        rr_model = first;
        drain();
    endtask

    task automatic run_single(input int i, input int n, input int minlen, input int maxlen, input int gap);
        for (int k = 0; k < n; k++) begin
            gen_pkt(i, $urandom_range(minlen, maxlen));
            ord_q.push_back(i);
        end
        drive_src(i, gap);
        rr_model = (i == 0);
        drain();
    endtask

    task automatic clear_model();
        src_q[0].delete();
        src_q[1].delete();
        exp_q[0].delete();
        exp_q[1].delete();
        ord_q.delete();
        cur_src      = -1;
        cnt_model[0] = '0;
        cnt_model[1] = '0;
        rr_model     = 1'b0;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        fails++;
        $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
        $fatal(1);
    end

    initial begin
        en      = 2'b11;
        s_valid = 2'b00;
        s_last  = 2'b00;
        s_data  = '{default: '0};
        s_keep  = '{default: '0};
        d_ready = 1'b1;
        clear_model();

        // Reset state
        #2 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_dst_valid", dst_if.t_valid, 1'b0);
        chk("rst_dst_last", dst_if.t_last, 1'b0);
        chk("rst_dst_data", dst_if.t_data, 64'd0);
        chk("rst_dst_keep", dst_if.t_keep, 8'd0);
        chk("rst_grant", grant, 2'b00);
        chk("rst_busy", busy, 1'b0);
        chk("rst_cnt", {pkt_cnt1, pkt_cnt0}, '0);
        chk("rst_src_ready", {src1_if.t_ready, src0_if.t_ready}, 2'b00);
        rst = 1'b1;
        @(posedge clk);
        #1;
        mon_en = 1'b1;

        // src0 alone, 3-beat packet
        gen_pkt(0, 3);
        ord_q.push_back(0);
        fork
            drive_src(0, 0);
            begin
                @(negedge clk);
                chk("single_bubble_grant", grant, 2'b00);
                @(negedge clk);
                chk("single_grant", grant, 2'b01);
            end
        join
        rr_model = 1'b1;
        drain();
        chk("single_pkt_cnt0", pkt_cnt0, 4'd1);

        // Both valid, 2-beat packets
        run_both(3, 2, 2);

        // dst stall for 3 cycles mid-packet
        gen_pkt(1, 5);
        ord_q.push_back(1);
        fork
            drive_src(1, 0);
            begin
                repeat (4) @(posedge clk);
                #1 d_ready = 1'b0;
                repeat (3) @(posedge clk);
                #1 d_ready = 1'b1;
            end
        join
        rr_model = 1'b0;
        drain();

        // en[1] dropped after the first beat of a src1 packet
        gen_pkt(1, 4);
        ord_q.push_back(1);
        fork
            drive_src(1, 0);
            begin
                int n;
                n = 0;
                do begin
                    @(negedge clk);
                    n++;
                end while (!(s_valid[1] && src1_if.t_ready) && n < BUDGET);
                @(posedge clk);
                #1 en[1] = 1'b0;
            end
        join
        rr_model = 1'b0;
        drain();
        gen_pkt(1, 2);
        ord_q.push_back(1);
        fork
            drive_src(1, 0);
            begin
                repeat (5) begin
                    @(negedge clk);
                    chk("en_masked_grant", grant, 2'b00);
                    chk("en_masked_ready", src1_if.t_ready, 1'b0);
                end
                @(posedge clk);
                #1 en[1] = 1'b1;
                @(negedge clk);
                chk("en_bubble_grant", grant, 2'b00);
                @(negedge clk);
                chk("en_regrant", grant, 2'b10);
            end
        join
        rr_model = 1'b0;
        drain();

        // Random mix with random dst back-pressure
        rnd_ready = 1'b1;
        for (int it = 0; it < 12; it++) begin
            int mode;
            mode = $urandom_range(2);
            if (mode == 0) run_both($urandom_range(1, 3), 1, 6);
            else run_single(mode - 1, $urandom_range(1, 3), 1, 6, 40);
        end
        rnd_ready = 1'b0;
        @(posedge clk);
        #2 d_ready = 1'b1;
        @(posedge clk);
        #1;

        // Reset during beat 2 of a 4-beat src0 packet
        mon_en = 1'b0;
        for (int b = 0; b < 2; b++) begin
            int n;
            n = 0;
            s_valid[0] = 1'b1;
            s_data[0]  = {$urandom, $urandom};
            s_keep[0]  = 8'hFF;
            s_last[0]  = 1'b0;
            @(negedge clk);
            while (!src0_if.t_ready && n < BUDGET) begin
                @(negedge clk);
                n++;
            end
            if (n == BUDGET) fail_msg("rst_pkt_accept", "src0 beat not accepted");
            @(posedge clk);
            #1;
        end
        s_data[0] = {$urandom, $urandom};
        chk("pre_rst_valid", dst_if.t_valid, 1'b1);
        chk("pre_rst_grant", grant, 2'b01);
        #2 rst = 1'b0;
        #1;
        chk("async_rst_valid", dst_if.t_valid, 1'b0);
        chk("async_rst_last", dst_if.t_last, 1'b0);
        chk("async_rst_data", dst_if.t_data, 64'd0);
        chk("async_rst_grant", grant, 2'b00);
        chk("async_rst_busy", busy, 1'b0);
        chk("async_rst_cnt", {pkt_cnt1, pkt_cnt0}, '0);
        chk("async_rst_ready", src0_if.t_ready, 1'b0);
        s_valid = 2'b00;
        @(posedge clk);
        #2 rst = 1'b1;
        clear_model();
        @(posedge clk);
        #1;
        mon_en = 1'b1;
        run_both(1, 1, 3);

        // Counter wrap: 17 single-beat packets from src0
        mon_en = 1'b0;
        rst = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        clear_model();
        @(posedge clk);
        #1;
        mon_en = 1'b1;
        run_single(0, 17, 1, 1, 0);
        chk("wrap_pkt_cnt0", pkt_cnt0, 4'd1);
        chk("wrap_pkt_cnt1", pkt_cnt1, 4'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
        $finish;
    end

endmodule

// File: doc/chroma_stream_arbiter.md
Name: chroma_stream_arbiter

Overview:
- Shares a single chroma-conversion stream processor (packed Y'UV422 in, Y'UV444 out) between two upstream YUV422 sources, e.g. two decoder output channels.
- Arbitrates at packet granularity: a grant holds until the beat with t_last is accepted, then round-robins to the other source.
- Inserts one registered output stage so the converter's t_ready does not combine with upstream logic beyond one gate level.
- Data, t_keep and t_last are forwarded unmodified.

Parameters:
- PKT_CNT_W, 16: width of the per-source completed-packet counters.

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous active-low reset
- src0  nasti_stream_channel.slave  -  requester 0 stream (t_data[0] 64b, t_keep[0] 8b, t_last, t_valid, t_ready)
- src1  nasti_stream_channel.slave  -  requester 1 stream
- dst  nasti_stream_channel.master  -  to the converter's src port
- en  input  2  per-source enable; en[i]=0 masks new grants to src i
- grant  output  2  one-hot current owner, 2'b00 when idle
- busy  output  1  high while a grant is held or dst.t_valid is high
- pkt_cnt0  output  PKT_CNT_W  packets completed from src0 (t_last beats accepted on dst)
- pkt_cnt1  output  PKT_CNT_W  same for src1

Behaviour:
- Reset (async, rst=0), applied immediately regardless of state:
  - state=IDLE, rr pointer=0 (src0 preferred first).
  - dst.t_valid=0, dst.t_last=0, dst.t_data=0, dst.t_keep=0.
  - grant=0, busy=0, pkt_cnt0=pkt_cnt1=0.
  - src0.t_ready=src1.t_ready=0.
  - An in-flight packet is discarded. No partial-packet recovery; upstream restarts framing after reset.
- State machine (IDLE, OWN0, OWN1):
  - IDLE: candidates are c[i] = src_i.t_valid && en[i].
    - Both candidates: grant src[rr].
    - One candidate: grant that source.
    - None: stay IDLE.
    - Transition takes effect next cycle (one-cycle arbitration bubble). No src is ready while in IDLE.
  - OWNi: src_i.t_ready = !dst.t_valid || dst.t_ready (combinational); the other source's t_ready=0.
    - On a src_i handshake (t_valid && t_ready), next cycle: dst.t_data/t_keep/t_last <= src_i values, dst.t_valid <= 1.
    - If the accepted beat has t_last=1: next state IDLE, rr <= ~i.
  - dst stage: if dst.t_valid && !dst.t_ready, all dst fields hold stable. If dst.t_ready && no new beat, dst.t_valid <= 0.
- Latency: 1 cycle from src handshake to dst.t_valid. Full throughput (1 beat/cycle) within a packet.
- grant: registered, equals the one-hot state encoding. busy = (state!=IDLE) || dst.t_valid.
- Counters: pkt_cnt<i> increments on a dst handshake with dst.t_last=1 for a beat sourced from i. A 1-bit owner tag travels with the dst register for this. Counters wrap modulo 2^PKT_CNT_W.
- en changes:
  - Deasserting en[i] during OWNi does not truncate; the packet completes.
  - Affects arbitration only in IDLE.
  - en=2'b00 with valid sources: remain IDLE, sources stalled.
- Single-beat packet (t_last on first beat): one beat, then IDLE.
- Simultaneous events:
  - Last beat accepted on src while the previous beat drains on dst in the same cycle is legal. The dst register reloads, with no bubble.
  - Next grant may occur while the final dst beat is still stalled. The new owner's t_ready stays 0 until the dst register frees.
- t_valid from a non-granted source is never dropped. It waits, and the protocol requires the source to hold it.
- No data or t_keep checking is done. Partial-keep beats pass through unchanged.

Test Plan:
- Only src0 valid, en=2'b11, 3-beat packet D0..D2 (t_last on D2), dst.t_ready=1:
  - grant=01 one cycle after src0.t_valid rises.
  - D0..D2 on dst on consecutive cycles, each 1 cycle after its src handshake.
  - pkt_cnt0=1, then IDLE, grant=00.
- Both sources continuously valid, 2-beat packets:
  - dst order src0,src0,src1,src1,src0,…
  - Exactly one idle cycle of src acceptance between packets; counters advance alternately.
- dst.t_ready=0 for 3 cycles mid-packet:
  - dst.t_data/t_keep/t_last unchanged across the stall.
  - Owner's t_ready=0 during the stall.
  - Beat sequence on dst identical to the input, with no loss or duplication.
- en[1] cleared after the first beat of a src1 4-beat packet:
  - All 4 beats forwarded, then no src1 grant while src1.t_valid=1.
  - Setting en[1]=1 grants src1 next IDLE cycle.
- rst asserted mid-packet (beat 2 of 4):
  - dst.t_valid, grant, busy, counters go 0 without waiting for clk.
  - After release with both valid, src0 is granted first.
- PKT_CNT_W=4, 17 single-beat packets from src0 only: pkt_cnt0 reads 1 (wrap at 16), pkt_cnt1=0.
